// File: rtl/airlock_sequencer_if.sv
// Airlock sequencer request/status bundle.
// The master side (user-input logic) raises 1-cycle request pulses and
// observes the door, pressure and dock status driven by the sequencer.
interface airlock_sequencer_if #(
  parameter int CNT_W = 10
);
  // Request pulses
  logic             arrive_req;
  logic             depart_req;
  logic             outer_tgl_req;
  logic             inner_tgl_req;
  logic             fill_req;
  logic             evac_req;
  logic             abort;

  // Status
  logic             outer_open;
  logic             inner_open;
  logic             pressurized;
  logic             evacuated;
  logic             busy;
  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic             dock_active;
  logic             dock_dir;
  logic [CNT_W-1:0] dock_count;
  logic             fault;

  modport master (
    output arrive_req, depart_req, outer_tgl_req, inner_tgl_req,
           fill_req, evac_req, abort,
    input  outer_open, inner_open, pressurized, evacuated, busy,
           state, count, dock_active, dock_dir, dock_count, fault
  );

  modport slave (
    input  arrive_req, depart_req, outer_tgl_req, inner_tgl_req,
           fill_req, evac_req, abort,
    output outer_open, inner_open, pressurized, evacuated, busy,
           state, count, dock_active, dock_dir, dock_count, fault
  );
endinterface

// File: rtl/airlock_sequencer.sv
// Airlock interlock sequencer.
// One FSM owns the door, pressure and fill/drain countdown state; an
// independent dock countdown shares the same prescaler tick. Conflicting
// or illegal request pulses are resolved by fixed priority
// (abort > fill/evac > outer > inner) and reported as a 1-cycle fault.
module airlock_sequencer #(
  parameter int TICK_DIV  = 50000000,
  parameter int CNT_W     = 10,
  parameter int FILL_SECS = 7,
  parameter int EVAC_SECS = 8,
  parameter int DOCK_SECS = 5
) (
  input logic               clk,
  input logic               rst,
  airlock_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_EVAC  = 3'd0,
    ST_FILL  = 3'd1,
    ST_PRESS = 3'd2,
    ST_DRAIN = 3'd3
  } state_t;

  localparam int               PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ONE = PW'(1);
  localparam logic [PW-1:0]    PRESC_ZERO = {PW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FILL_LD   = CNT_W'(FILL_SECS);
  localparam logic [CNT_W-1:0] EVAC_LD   = CNT_W'(EVAC_SECS);
  localparam logic [CNT_W-1:0] DOCK_LD   = CNT_W'(DOCK_SECS);

  // Registered state and outputs
  state_t           state_r;
  logic [CNT_W-1:0] count_r;
  logic [PW-1:0]    presc_r;
  logic             outer_r;
  logic             inner_r;
  logic             pressurized_r;
  logic             evacuated_r;
  logic             busy_r;
  logic             dock_active_r;
  logic             dock_dir_r;
  logic [CNT_W-1:0] dock_count_r;
  logic             fault_r;

  // Combinational decode
  logic             tick_s;
  logic             doors_closed_s;
  logic             abort_ok_s;
  logic             fill_ok_s;
  logic             evac_ok_s;
  logic             outer_ok_s;
  logic             inner_ok_s;
  logic             sel_abort_s;
  logic             sel_fill_s;
  logic             sel_evac_s;
  logic             sel_outer_s;
  logic             sel_inner_s;
  logic             main_fault_s;
  logic             dock_fault_s;
  logic             dock_load_s;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             outer_nxt_s;
  logic             inner_nxt_s;
  logic             presc_clr_s;

  assign tick_s         = (presc_r == PRESC_MAX);
  assign doors_closed_s = ~outer_r & ~inner_r;

  // Request legality and priority selection for the main FSM
  always_comb begin
    abort_ok_s  = bus.abort & ((state_r == ST_FILL) | (state_r == ST_DRAIN));
    fill_ok_s   = bus.fill_req & (state_r == ST_EVAC) & doors_closed_s;
    evac_ok_s   = bus.evac_req & (state_r == ST_PRESS) & doors_closed_s;
    outer_ok_s  = bus.outer_tgl_req & (state_r == ST_EVAC) & ~inner_r;
    inner_ok_s  = bus.inner_tgl_req & (state_r == ST_PRESS) & ~outer_r;

    sel_abort_s = abort_ok_s;
    sel_fill_s  = ~abort_ok_s & fill_ok_s;
    sel_evac_s  = ~abort_ok_s & evac_ok_s;
    sel_outer_s = ~abort_ok_s & ~fill_ok_s & ~evac_ok_s & outer_ok_s;
    sel_inner_s = ~abort_ok_s & ~fill_ok_s & ~evac_ok_s & ~outer_ok_s & inner_ok_s;

    // An abort outside FILL/DRAIN is silently dropped; every other
    // request that was not the one accepted counts as rejected.
    main_fault_s = (bus.fill_req      & ~sel_fill_s)  |
                   (bus.evac_req      & ~sel_evac_s)  |
                   (bus.outer_tgl_req & ~sel_outer_s) |
                   (bus.inner_tgl_req & ~sel_inner_s);
  end

  // Dock request acceptance: arrive wins a tie, anything while busy is rejected
  always_comb begin
    dock_load_s = ~dock_active_r & (bus.arrive_req | bus.depart_req);
    if (dock_active_r) begin
      dock_fault_s = bus.arrive_req | bus.depart_req;
    end else begin
      dock_fault_s = bus.arrive_req & bus.depart_req;
    end
  end

  // Main FSM next-state, countdown and door decode
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    outer_nxt_s = outer_r;
    inner_nxt_s = inner_r;
    presc_clr_s = 1'b0;
    case (state_r)
      ST_EVAC: begin
        if (sel_fill_s) begin
          state_nxt_s = ST_FILL;
          count_nxt_s = FILL_LD;
          presc_clr_s = 1'b1;
        end else if (sel_outer_s) begin
          outer_nxt_s = ~outer_r;
        end else begin
          state_nxt_s = ST_EVAC;
        end
      end
      ST_FILL: begin
        if (sel_abort_s) begin
          state_nxt_s = ST_EVAC;
          count_nxt_s = CNT_ZERO;
        end else if (tick_s) begin
          if (count_r == CNT_ONE) begin
            state_nxt_s = ST_PRESS;
            count_nxt_s = CNT_ZERO;
          end else begin
            count_nxt_s = count_r - CNT_ONE;
          end
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_PRESS: begin
        if (sel_evac_s) begin
          state_nxt_s = ST_DRAIN;
          count_nxt_s = EVAC_LD;
          presc_clr_s = 1'b1;
        end else if (sel_inner_s) begin
          inner_nxt_s = ~inner_r;
        end else begin
          state_nxt_s = ST_PRESS;
        end
      end
      ST_DRAIN: begin
        if (sel_abort_s) begin
          state_nxt_s = ST_PRESS;
          count_nxt_s = CNT_ZERO;
        end else if (tick_s) begin
          if (count_r == CNT_ONE) begin
            state_nxt_s = ST_EVAC;
            count_nxt_s = CNT_ZERO;
          end else begin
            count_nxt_s = count_r - CNT_ONE;
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_EVAC;
        count_nxt_s = CNT_ZERO;
        outer_nxt_s = 1'b0;
        inner_nxt_s = 1'b0;
      end
    endcase
  end

  // State, prescaler, dock channel and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_EVAC;
      count_r       <= CNT_ZERO;
      presc_r       <= PRESC_ZERO;
      outer_r       <= 1'b0;
      inner_r       <= 1'b0;
      pressurized_r <= 1'b0;
      evacuated_r   <= 1'b1;
      busy_r        <= 1'b0;
      dock_active_r <= 1'b0;
      dock_dir_r    <= 1'b0;
      dock_count_r  <= CNT_ZERO;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      count_r       <= count_nxt_s;
      outer_r       <= outer_nxt_s;
      inner_r       <= inner_nxt_s;
      pressurized_r <= (state_nxt_s == ST_PRESS);
      evacuated_r   <= (state_nxt_s == ST_EVAC);
      busy_r        <= (state_nxt_s == ST_FILL) | (state_nxt_s == ST_DRAIN);
      fault_r       <= main_fault_s | dock_fault_s;

      // Restart the prescaler on a countdown load so the first tick is a full period away
      if (presc_clr_s | tick_s) begin
        presc_r <= PRESC_ZERO;
      end else begin
        presc_r <= presc_r + PRESC_ONE;
      end

      if (dock_load_s) begin
        dock_active_r <= 1'b1;
        dock_dir_r    <= bus.arrive_req;
        dock_count_r  <= DOCK_LD;
      end else if (dock_active_r & tick_s) begin
        dock_count_r  <= dock_count_r - CNT_ONE;
        dock_active_r <= (dock_count_r != CNT_ONE);
      end else begin
        dock_active_r <= dock_active_r;
      end
    end
  end

  assign bus.state       = state_r;
  assign bus.count       = count_r;
  assign bus.outer_open  = outer_r;
  assign bus.inner_open  = inner_r;
  assign bus.pressurized = pressurized_r;
  assign bus.evacuated   = evacuated_r;
  assign bus.busy        = busy_r;
  assign bus.dock_active = dock_active_r;
  assign bus.dock_dir    = dock_dir_r;
  assign bus.dock_count  = dock_count_r;
  assign bus.fault       = fault_r;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer with small tick/duration parameters.
module tb_airlock_sequencer;

  localparam int CNT_W = 10;

  // Request bit positions for the pulse task
  localparam int B_ARR   = 6;
  localparam int B_DEP   = 5;
  localparam int B_OUTER = 4;
  localparam int B_INNER = 3;
  localparam int B_FILL  = 2;
  localparam int B_EVAC  = 1;
  localparam int B_ABORT = 0;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  airlock_sequencer_if #(.CNT_W(CNT_W)) bus ();

  airlock_sequencer #(
    .TICK_DIV (4),
    .CNT_W    (CNT_W),
    .FILL_SECS(3),
    .EVAC_SECS(2),
    .DOCK_SECS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] r);
    bus.arrive_req    = r[B_ARR];
    bus.depart_req    = r[B_DEP];
    bus.outer_tgl_req = r[B_OUTER];
    bus.inner_tgl_req = r[B_INNER];
    bus.fill_req      = r[B_FILL];
    bus.evac_req      = r[B_EVAC];
    bus.abort         = r[B_ABORT];
  endtask

  // Hold the request vector for exactly one sampling edge, then look #1 later
  task automatic pulse(input logic [6:0] r);
    drive(r);
    @(posedge clk);
    #1;
    drive(7'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] rq(input int b);
    logic [6:0] v;
    v = 7'd0;
    v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    drive(7'd0);

    // Reset
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    chk("rst_state", bus.state, 3'd0);
    chk("rst_evacuated", bus.evacuated, 1'b1);
    chk("rst_press", bus.pressurized, 1'b0);
    chk("rst_outer", bus.outer_open, 1'b0);
    chk("rst_inner", bus.inner_open, 1'b0);
    chk("rst_count", bus.count, 10'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_fault", bus.fault, 1'b0);
    chk("rst_dock_active", bus.dock_active, 1'b0);
    chk("rst_dock_count", bus.dock_count, 10'd0);
    chk("rst_dock_dir", bus.dock_dir, 1'b0);

    // Inner toggle is illegal in EVAC
    pulse(rq(B_INNER));
    chk("evac_inner_fault", bus.fault, 1'b1);
    chk("evac_inner_door", bus.inner_open, 1'b0);
    chk("evac_inner_state", bus.state, 3'd0);
    cycles(1);
    chk("fault_one_cycle", bus.fault, 1'b0);

    // Fill countdown
    pulse(rq(B_FILL));
    chk("fill_state", bus.state, 3'd1);
    chk("fill_count3", bus.count, 10'd3);
    chk("fill_busy", bus.busy, 1'b1);
    chk("fill_evac_low", bus.evacuated, 1'b0);
    cycles(3);
    chk("fill_c4_count", bus.count, 10'd3);
    cycles(1);
    chk("fill_c5_count", bus.count, 10'd2);
    cycles(4);
    chk("fill_c9_count", bus.count, 10'd1);
    chk("fill_c9_state", bus.state, 3'd1);
    cycles(4);
    chk("press_state", bus.state, 3'd2);
    chk("press_flag", bus.pressurized, 1'b1);
    chk("press_count", bus.count, 10'd0);
    chk("press_busy", bus.busy, 1'b0);
    chk("press_evac_low", bus.evacuated, 1'b0);

    // Inner door in PRESS, then evac with door open is rejected
    pulse(rq(B_INNER));
    chk("press_inner_open", bus.inner_open, 1'b1);
    chk("press_inner_nofault", bus.fault, 1'b0);
    pulse(rq(B_EVAC));
    chk("evac_door_open_fault", bus.fault, 1'b1);
    chk("evac_door_open_state", bus.state, 3'd2);
    pulse(rq(B_INNER));
    chk("press_inner_close", bus.inner_open, 1'b0);

    // evac beats inner toggle in the same cycle
    pulse(rq(B_EVAC) | rq(B_INNER));
    chk("prio_drain_state", bus.state, 3'd3);
    chk("prio_drain_count", bus.count, 10'd2);
    chk("prio_fault", bus.fault, 1'b1);
    chk("prio_inner_closed", bus.inner_open, 1'b0);
    chk("drain_press_low", bus.pressurized, 1'b0);

    // Abort in DRAIN returns to PRESS
    pulse(rq(B_ABORT));
    chk("abort_drain_state", bus.state, 3'd2);
    chk("abort_drain_count", bus.count, 10'd0);
    chk("abort_drain_busy", bus.busy, 1'b0);
    chk("abort_drain_fault", bus.fault, 1'b0);

    // Lone abort outside FILL/DRAIN is ignored quietly
    pulse(rq(B_ABORT));
    chk("abort_idle_fault", bus.fault, 1'b0);
    chk("abort_idle_state", bus.state, 3'd2);

    // Full drain back to EVAC
    pulse(rq(B_EVAC));
    chk("drain_count2", bus.count, 10'd2);
    cycles(4);
    chk("drain_count1", bus.count, 10'd1);
    cycles(4);
    chk("drain_done_state", bus.state, 3'd0);
    chk("drain_done_evac", bus.evacuated, 1'b1);
    chk("drain_done_count", bus.count, 10'd0);

    // Outer door blocks fill
    pulse(rq(B_OUTER));
    chk("outer_open", bus.outer_open, 1'b1);
    pulse(rq(B_FILL));
    chk("fill_door_fault", bus.fault, 1'b1);
    chk("fill_door_state", bus.state, 3'd0);
    pulse(rq(B_OUTER));
    chk("outer_close", bus.outer_open, 1'b0);

    // fill beats outer toggle; then abort in FILL
    pulse(rq(B_FILL) | rq(B_OUTER));
    chk("prio_fill_state", bus.state, 3'd1);
    chk("prio_fill_fault", bus.fault, 1'b1);
    chk("prio_fill_outer", bus.outer_open, 1'b0);
    pulse(rq(B_ABORT));
    chk("abort_fill_state", bus.state, 3'd0);
    chk("abort_fill_count", bus.count, 10'd0);
    chk("abort_fill_fault", bus.fault, 1'b0);

    // Reset mid-FILL wins over a simultaneous request
    pulse(rq(B_FILL));
    cycles(4);
    chk("midfill_count", bus.count, 10'd2);
    rst = 1'b1;
    drive(rq(B_OUTER));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(7'd0);
    chk("midrst_state", bus.state, 3'd0);
    chk("midrst_count", bus.count, 10'd0);
    chk("midrst_presc", 32'(dut.presc_r), 32'd0);
    chk("midrst_fault", bus.fault, 1'b0);
    chk("midrst_outer", bus.outer_open, 1'b0);
    chk("midrst_evac", bus.evacuated, 1'b1);

    // Dock: simultaneous arrive/depart
    pulse(rq(B_ARR) | rq(B_DEP));
    chk("dock_active", bus.dock_active, 1'b1);
    chk("dock_dir_arrive", bus.dock_dir, 1'b1);
    chk("dock_count2", bus.dock_count, 10'd2);
    chk("dock_tie_fault", bus.fault, 1'b1);
    cycles(3);
    chk("dock_count1", bus.dock_count, 10'd1);
    chk("dock_still_active", bus.dock_active, 1'b1);
    pulse(rq(B_DEP));
    chk("dock_busy_fault", bus.fault, 1'b1);
    chk("dock_busy_dir", bus.dock_dir, 1'b1);
    cycles(3);
    chk("dock_done_active", bus.dock_active, 1'b0);
    chk("dock_done_count", bus.dock_count, 10'd0);
    chk("dock_dir_held", bus.dock_dir, 1'b1);
    pulse(rq(B_DEP));
    chk("depart_active", bus.dock_active, 1'b1);
    chk("depart_dir", bus.dock_dir, 1'b0);
    chk("depart_fault", bus.fault, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
